// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback controller: opcodes,
// FSM states and instruction field positions.
package alu_issue_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam int INSTR_W  = 11;
  localparam int F_USE_C  = 10;
  localparam int F_SET_F  = 9;
  localparam int F_OP_HI  = 8;
  localparam int F_OP_LO  = 6;
  localparam int F_RD_HI  = 5;
  localparam int F_RD_LO  = 4;
  localparam int F_RS1_HI = 3;
  localparam int F_RS1_LO = 2;
  localparam int F_RS2_HI = 1;
  localparam int F_RS2_LO = 0;

  // Position of each flag inside flags_nzcv = {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int NUM_REGS = 4;

endpackage

// File: rtl/alu_issue_regfile.sv
// Four-entry register file: one synchronous write port, three
// combinational read ports (two operands plus a debug tap).
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH:0]   wdata,
  input  logic [1:0]       raddr1,
  output logic [WIDTH:0]   rdata1,
  input  logic [1:0]       raddr2,
  output logic [WIDTH:0]   rdata2,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH:0]   dbg_rdata
);

  logic [WIDTH:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1    = mem[raddr1];
  assign rdata2    = mem[raddr2];
  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle execute unit wrapped around an external combinational ALU:
// IDLE accepts, READ fetches operands, EXEC captures the ALU, WB commits.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [WIDTH:0]     alu_a,
  output logic [WIDTH:0]     alu_b,
  output logic [2:0]         alu_op,
  output logic               alu_ci,
  input  logic [WIDTH:0]     alu_out,
  input  logic               alu_n,
  input  logic               alu_z,
  input  logic               alu_c,
  input  logic               alu_v,
  output logic               done,
  output logic [WIDTH:0]     result,
  output logic [3:0]         flags_nzcv,
  input  logic [1:0]         dbg_sel,
  output logic [WIDTH:0]     dbg_data
);

  localparam int DW    = WIDTH + 1;
  localparam int IMM_W = (DW < 4) ? DW : 4;

  // Handshake: an instruction transfers on a rising edge where
  // instr_valid && instr_ready; ready is high only in IDLE and the source
  // must hold instr stable until it transfers.

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [WIDTH:0]     cap_val;
  logic [3:0]         cap_flags;

  logic               use_c, set_f;
  logic [2:0]         op;
  logic [1:0]         rd, rs1, rs2;
  logic [3:0]         imm4;
  logic [WIDTH:0]     imm;
  logic [WIDTH:0]     rd1_data, rd2_data;
  logic               wb_we;

  assign use_c = instr_q[F_USE_C];
  assign set_f = instr_q[F_SET_F];
  assign op    = instr_q[F_OP_HI:F_OP_LO];
  assign rd    = instr_q[F_RD_HI:F_RD_LO];
  assign rs1   = instr_q[F_RS1_HI:F_RS1_LO];
  assign rs2   = instr_q[F_RS2_HI:F_RS2_LO];
  assign imm4  = {rs1, rs2};

  // LDI immediate: zero-extended, or truncated on narrow data paths.
  always_comb begin
    imm = '0;
    imm[IMM_W-1:0] = imm4[IMM_W-1:0];
  end

  alu_issue_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (wb_we),
    .waddr     (rd),
    .wdata     (cap_val),
    .raddr1    (rs1),
    .rdata1    (rd1_data),
    .raddr2    (rs2),
    .rdata2    (rd2_data),
    .dbg_addr  (dbg_sel),
    .dbg_rdata (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    wb_we       = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        done    = 1'b1;
        wb_we   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_ci     <= 1'b0;
      cap_val    <= '0;
      cap_flags  <= '0;
      result     <= '0;
      flags_nzcv <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
          end
        end
        READ: begin
          alu_a  <= rd1_data;
          alu_b  <= rd2_data;
          alu_op <= op;
          alu_ci <= use_c ? flags_nzcv[FLAG_C] : 1'b0;
        end
        EXEC: begin
          cap_val   <= (op == OP_LDI) ? imm : alu_out;
          cap_flags <= {alu_n, alu_z, alu_c, alu_v};
        end
        WB: begin
          result <= cap_val;
          // LDI never touches the flags, even with set_f.
          if (set_f && (op != OP_LDI)) begin
            flags_nzcv <= cap_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the alu_* ports, directed
// table, hold/abort sequences and random instructions against a model.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 3;
  localparam int DW    = WIDTH + 1;

  logic          clk, rst;
  logic          instr_valid;
  logic [10:0]   instr;
  logic          instr_ready;
  logic [DW-1:0] alu_a, alu_b, alu_out, result, dbg_data;
  logic [2:0]    alu_op;
  logic          alu_ci, alu_n, alu_z, alu_c, alu_v, done;
  logic [3:0]    flags_nzcv;
  logic [1:0]    dbg_sel;

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_ci      (alu_ci),
    .alu_out     (alu_out),
    .alu_n       (alu_n),
    .alu_z       (alu_z),
    .alu_c       (alu_c),
    .alu_v       (alu_v),
    .done        (done),
    .result      (result),
    .flags_nzcv  (flags_nzcv),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- ALU model and reference ----------------
  typedef struct packed {
    logic [DW-1:0] r;
    logic [3:0]    f;
  } alu_res_t;

  function automatic alu_res_t alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b, input logic ci);
    alu_res_t res;
    int       s;
    logic     c, v;
    res.r = '0;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    case (op)
      3'd0: res.r = a & b;
      3'd1: begin
        s = int'(a) + int'(b) + int'(ci);
        res.r = s[DW-1:0];
        c = (s >= (1 << DW));
        v = (a[DW-1] == b[DW-1]) && (res.r[DW-1] != a[DW-1]);
      end
      3'd2: begin
        s = int'(a) - int'(b) - int'(ci);
        res.r = s[DW-1:0];
        c = (s < 0);
        v = (a[DW-1] != b[DW-1]) && (res.r[DW-1] != a[DW-1]);
      end
      3'd3: res.r = a | b;
      3'd4: res.r = a ^ b;
      3'd5: begin res.r = a << 1; c = a[DW-1]; end
      3'd6: begin res.r = a >> 1; c = a[0]; end
      default: res.r = '0;
    endcase
    res.f = {res.r[DW-1], (res.r == '0), c, v};
    return res;
  endfunction

  alu_res_t alu_now;
  always_comb begin
    alu_now = alu_ref(alu_op, alu_a, alu_b, alu_ci);
    alu_out = alu_now.r;
    {alu_n, alu_z, alu_c, alu_v} = alu_now.f;
  end

  // Architectural model: register contents and flag register.
  logic [DW-1:0] regs_m [4];
  logic [3:0]    flags_m;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic uc, input logic sf, input logic [2:0] op,
                                     input logic [1:0] rd, input logic [1:0] rs1,
                                     input logic [1:0] rs2);
    return {uc, sf, op, rd, rs1, rs2};
  endfunction

  task automatic check_reset_state();
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'(flags_nzcv), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check("rst_dbg", 32'(dbg_data), 32'd0);
    end
  endtask

  // ---------------- driver ----------------
  // Starts and ends just after a falling edge. With hold=1 the next
  // instruction is presented while busy and must be taken only in IDLE.
  task automatic run_instr(input logic [10:0] ins, input bit hold, input logic [10:0] nxt,
                           output logic [DW-1:0] obs_r, output logic [3:0] obs_f);
    logic [2:0]    op;
    logic [1:0]    rd, rs1, rs2;
    logic [DW-1:0] a, b, val;
    logic          ci;
    logic [3:0]    fl;
    alu_res_t      ar;
    int            n, dc0;
    op  = ins[8:6];
    rd  = ins[5:4];
    rs1 = ins[3:2];
    rs2 = ins[1:0];
    a   = regs_m[rs1];
    b   = regs_m[rs2];
    ci  = ins[10] ? flags_m[1] : 1'b0;
    fl  = flags_m;
    if (op == 3'd7) begin
      val = {rs1, rs2};
    end else begin
      ar  = alu_ref(op, a, b, ci);
      val = ar.r;
      if (ins[9]) fl = ar.f;
    end
    exp_q.push_back(val);

    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(instr_ready), 32'd1);
    dc0 = done_cnt;
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    if (hold) instr = nxt;
    else instr_valid = 1'b0;
    check("busy_ready", 32'(instr_ready), 32'd0);
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        check("exec_alu_a", 32'(alu_a), 32'(a));
        check("exec_alu_b", 32'(alu_b), 32'(b));
        check("exec_alu_op", 32'(alu_op), 32'(op));
        check("exec_alu_ci", 32'(alu_ci), 32'(ci));
        check("exec_ready", 32'(instr_ready), 32'd0);
      end
    end
    check("done_latency", 32'(n), 32'd3);
    check("wb_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check("idle_ready", 32'(instr_ready), 32'd1);
    check("done_pulse", 32'(done), 32'd0);
    check("result", 32'(result), 32'(exp_q.pop_front()));
    check("flags", 32'(flags_nzcv), 32'(fl));
    check("done_count", 32'(done_cnt - dc0), 32'd1);
    dbg_sel = rd;
    #1;
    check("dbg_rd", 32'(dbg_data), 32'(val));
    regs_m[rd] = val;
    flags_m = fl;
    obs_r = result;
    obs_f = flags_nzcv;
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [10:0]   ins;
    logic [DW-1:0] r;
    logic [3:0]    f;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [DW-1:0] r;
    logic [3:0]    f;
    logic [10:0]   cur, nxt;
    bit            hold;
    int            dc0;

    tbl[0]  = '{mk(0, 0, 3'd7, 2'd1, 2'd1, 2'd3), 4'b0111, 4'b0000};
    tbl[1]  = '{mk(0, 0, 3'd7, 2'd2, 2'd0, 2'd2), 4'b0010, 4'b0000};
    tbl[2]  = '{mk(0, 1, 3'd1, 2'd3, 2'd1, 2'd2), 4'b1001, 4'b1001};
    tbl[3]  = '{mk(0, 0, 3'd7, 2'd1, 2'd3, 2'd1), 4'b1101, 4'b1001};
    tbl[4]  = '{mk(0, 0, 3'd7, 2'd2, 2'd0, 2'd3), 4'b0011, 4'b1001};
    tbl[5]  = '{mk(0, 1, 3'd1, 2'd0, 2'd1, 2'd2), 4'b0000, 4'b0110};
    tbl[6]  = '{mk(1, 0, 3'd1, 2'd3, 2'd2, 2'd2), 4'b0111, 4'b0110};
    tbl[7]  = '{mk(0, 0, 3'd2, 2'd0, 2'd1, 2'd1), 4'b0000, 4'b0110};
    tbl[8]  = '{mk(0, 1, 3'd7, 2'd0, 2'd3, 2'd3), 4'b1111, 4'b0110};
    tbl[9]  = '{mk(0, 1, 3'd2, 2'd2, 2'd0, 2'd1), 4'b0010, 4'b0000};
    tbl[10] = '{mk(0, 1, 3'd5, 2'd1, 2'd1, 2'd0), 4'b1010, 4'b1010};
    tbl[11] = '{mk(0, 1, 3'd6, 2'd3, 2'd0, 2'd0), 4'b0111, 4'b0010};
    tbl[12] = '{mk(0, 1, 3'd4, 2'd0, 2'd0, 2'd0), 4'b0000, 4'b0100};

    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dbg_sel = '0;
    for (int i = 0; i < 4; i++) regs_m[i] = '0;
    flags_m = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state();

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].ins, 1'b0, 11'd0, r, f);
      check("tbl_result", 32'(r), 32'(tbl[i].r));
      check("tbl_flags", 32'(f), 32'(tbl[i].f));
    end

    // Back-to-back: second instruction held valid while the first runs.
    run_instr(mk(0, 0, 3'd7, 2'd0, 2'd1, 2'd1), 1'b1, mk(0, 1, 3'd1, 2'd1, 2'd0, 2'd0), r, f);
    check("hold_ldi", 32'(r), 32'h5);
    run_instr(mk(0, 1, 3'd1, 2'd1, 2'd0, 2'd0), 1'b0, 11'd0, r, f);
    check("hold_add", 32'(r), 32'hA);
    check("hold_flags", 32'(f), 32'b1001);

    // Abort in EXEC: no done, everything back to reset values.
    dc0 = done_cnt;
    instr_valid = 1'b1;
    instr = mk(0, 1, 3'd1, 2'd3, 2'd1, 2'd2);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("abort_exec_op", 32'(alu_op), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_op_async", 32'(alu_op), 32'd0);
    check("abort_ready_async", 32'(instr_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    check_reset_state();
    for (int i = 0; i < 4; i++) regs_m[i] = '0;
    flags_m = '0;

    // Random instructions against the model.
    cur = 11'($urandom_range(0, 2047));
    for (int i = 0; i < 40; i++) begin
      nxt  = 11'($urandom_range(0, 2047));
      hold = ($urandom_range(0, 1) == 1) && (i < 39);
      run_instr(cur, hold, nxt, r, f);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      cur = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback controller on the driving side of the combinational ALU.
- Accepts an 11-bit instruction over a valid/ready handshake and reads two operands from an internal 4-entry register file.
- Drives opcode, operands and carry-in to the ALU, then captures its result and flags (N, Z, C, V).
- Writes the result back to the register file and updates a sticky flag register, turning the bare ALU into a multi-cycle execute unit.

Parameters:
WIDTH, 3, MSB index of the data path (data is WIDTH+1 bits, same convention as the ALU).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
instr_valid  in  1  instruction present.
instr  in  11  [10] use_c, [9] set_f, [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
instr_ready  out  1  high only in IDLE.
alu_a  out  WIDTH+1  operand A to ALU (registered).
alu_b  out  WIDTH+1  operand B to ALU (registered).
alu_op  out  3  ALU opCode (registered).
alu_ci  out  1  ALU carry-in (registered).
alu_out  in  WIDTH+1  ALU result.
alu_n, alu_z, alu_c, alu_v  in  1 each  ALU negativo, cero, acarreo, desbordamiento.
done  out  1  one-cycle pulse in WB.
result  out  WIDTH+1  value written in WB, held until next WB.
flags_nzcv  out  4  flag register {N,Z,C,V}.
dbg_sel  in  2  register-file read select.
dbg_data  out  WIDTH+1  combinational read of regfile[dbg_sel].

Behaviour:
- Reset (async, rst=1): state IDLE; regfile all 0; alu_a/alu_b/alu_op/alu_ci = 0; result = 0; flags_nzcv = 0000; done = 0; instr_ready = 1 once IDLE is entered.
- Opcodes: 000 AND, 001 ADD, 010 SUB, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 LDI.
- LDI: rd <= zero-extended {rs1,rs2} immediate. The ALU is not used. If WIDTH+1 < 4, the immediate is truncated to the low bits.
- FSM IDLE -> READ -> EXEC -> WB -> IDLE, one cycle per state except IDLE.
- IDLE: on instr_valid && instr_ready, latch instr and go to READ. instr_valid with ready low is ignored; the source holds the instruction.
- READ: load alu_a <= reg[rs1], alu_b <= reg[rs2], alu_op <= op, alu_ci <= use_c ? flags_nzcv[1] : 0.
- EXEC: ALU settles. At the end of the cycle, capture alu_out (or the immediate for LDI) and alu_n/z/c/v.
- WB: reg[rd] <= captured value; result <= captured value; done = 1.
  - If set_f=1 and op != 111, flags_nzcv <= captured flags; otherwise flags are unchanged.
- Latency: acceptance edge to done is 3 cycles. Throughput is one instruction per 4 cycles; instr_ready returns to 1 the cycle after WB.
- No hazards: the block is strictly sequential, so rs == rd of the previous instruction reads the written-back value.
- rd == rs1 == rs2 is legal; operands are read in READ, before WB.
- Arithmetic width and wrap-around are owned by the ALU. The controller never widens or modifies alu_out.
- Reset in any state aborts: no writeback, no done pulse, everything returns to reset values.
- dbg_data reflects a WB write from the following cycle.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode localparams (OP_AND..OP_LDI);
  - state enum typedef {IDLE, READ, EXEC, WB};
  - instruction field bit-position constants.
- One sub-module: alu_issue_regfile, 4 x (WIDTH+1) storage with async reset, one write port and three combinational read ports (rs1, rs2, dbg).
- The ALU itself stays outside; the bench instantiates it (or a model) on the alu_* ports.

Test Plan:
1. Reset: apply rst mid-sim -> instr_ready=1, done=0, flags_nzcv=0000, dbg_data=0000 for every dbg_sel.
2. LDI r1=0111, then LDI r2=0010, then ADD r3=r1+r2 with set_f=1 -> alu_op=001, alu_a=0111, alu_b=0010; done 3 cycles after acceptance; result=1001, dbg r3=1001, flags_nzcv={N,0,0,V} from the ALU.
3. LDI r1=1101, r2=0011; ADD r0 set_f -> result 0000, Z=1, C=1. Then ADD r3=r2+r2 with use_c=1 -> alu_ci=1 observed in EXEC.
4. SUB r0=r1-r1 with set_f=0 -> r0=0000, flags_nzcv unchanged from the previous value.
5. Hold instr_valid=1 with a new instruction during READ/EXEC/WB -> instr_ready=0 and no acceptance; accepted exactly on the first IDLE cycle; exactly one done per instruction.
6. Assert rst during EXEC of ADD r3 -> no done pulse, r3=0000 after release, FSM in IDLE, alu_op=000.
